// File: rtl/alu_pkg.sv
// Shared ALU opcode and status-flag definitions.
// Imported by alu_addsub and arithmetic_logic_unit.
package alu_pkg;

    localparam logic [2:0] ALU_SLT  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Bit positions inside flags_q = {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Ops that run the adder in subtract mode
    function automatic logic is_sub(input logic [2:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) ||
               (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor with carry-out and signed overflow.
// Ports: a, b, sub (1 = a-b), sum, cout, ovf.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   ext;

    // Subtract as a + ~b + 1; cout then means "no borrow"
    assign bx  = sub ? ~b : b;
    assign ext = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign sum  = ext[WIDTH-1:0];
    assign cout = ext[WIDTH];

    // Same-sign addends producing a different-sign sum
    assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) &&
                 (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle ALU: combinational result/zero/overflow plus a
// registered {N,Z,C,V} flag register. Ports: clk, reset_n, a, b,
// alucontrol, result, zero, overflow, flags_q.
module arithmetic_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [3:0]       flags_q
);

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             carry;
    logic             lt_s;
    logic             lt_u;
    logic [3:0]       flags_d;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (is_sub(alucontrol)),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    // True signed compare survives operand-range overflow
    assign lt_s = sum[WIDTH-1] ^ ovf;
    assign lt_u = ~cout;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        unique case (alucontrol)
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SUB: begin
                result   = sum;
                overflow = ovf;
                carry    = cout;
            end
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_ADD: begin
                result   = sum;
                overflow = ovf;
                carry    = cout;
            end
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = ~|result;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = result[WIDTH-1];
        flags_d[FLAG_Z] = zero;
        flags_d[FLAG_C] = carry;
        flags_d[FLAG_V] = overflow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed self-checking bench for arithmetic_logic_unit.
// Each task drives vectors and compares against hand values.
module tb_arithmetic_logic_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alucontrol;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [3:0]  flags_q;

    int total;
    int bad;

    localparam logic [2:0] SLT  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] XOR  = 3'b010;
    localparam logic [2:0] NOR  = 3'b011;
    localparam logic [2:0] SLTU = 3'b100;
    localparam logic [2:0] ADD  = 3'b101;
    localparam logic [2:0] OR   = 3'b110;
    localparam logic [2:0] AND  = 3'b111;

    arithmetic_logic_unit #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] op,
                         input logic [31:0] va,
                         input logic [31:0] vb);
        alucontrol = op;
        a = va;
        b = vb;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(ADD, 32'h7FFFFFFF, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (flags_q !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold%0d flags_q=%b want=0000",
                         i, flags_q);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_and;
        drive(AND, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++;
        if (result !== 32'hFFFFFFFF || zero !== 1'b0) begin
            bad++;
            $display("FAIL and_ones res=%h z=%b want=ffffffff z=0",
                     result, zero);
        end
        drive(AND, 32'h55555555, 32'hAAAAAAAA);
        total++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL and_alt res=%h z=%b want=0 z=1",
                     result, zero);
        end
        drive(AND, 32'd5, 32'd6);
        total++;
        if (result !== 32'd4 || zero !== 1'b0) begin
            bad++;
            $display("FAIL and_5_6 res=%h z=%b want=4 z=0",
                     result, zero);
        end
    endtask

    task automatic test_or;
        drive(OR, 32'h0, 32'h0);
        total++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL or_zero res=%h z=%b want=0 z=1",
                     result, zero);
        end
        drive(OR, 32'h55555555, 32'hAAAAAAAA);
        total++;
        if (result !== 32'hFFFFFFFF || zero !== 1'b0) begin
            bad++;
            $display("FAIL or_alt res=%h z=%b want=ffffffff z=0",
                     result, zero);
        end
        drive(OR, 32'd5, 32'd6);
        total++;
        if (result !== 32'd7 || zero !== 1'b0) begin
            bad++;
            $display("FAIL or_5_6 res=%h z=%b want=7 z=0",
                     result, zero);
        end
    endtask

    task automatic test_addsub;
        drive(ADD, 32'h7FFFFFFF, 32'h1);
        total++;
        if (result !== 32'h80000000 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL add_ovf res=%h v=%b want=80000000 v=1",
                     result, overflow);
        end
        drive(ADD, 32'hFFFFFFFF, 32'h1);
        total++;
        if (result !== 32'h0 || zero !== 1'b1 ||
            overflow !== 1'b0) begin
            bad++;
            $display("FAIL add_wrap res=%h z=%b v=%b want=0 z=1 v=0",
                     result, zero, overflow);
        end
        drive(SUB, 32'd5, 32'd5);
        total++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL sub_eq res=%h z=%b want=0 z=1",
                     result, zero);
        end
        drive(SUB, 32'd3, 32'd5);
        total++;
        if (result !== 32'hFFFFFFFE || zero !== 1'b0) begin
            bad++;
            $display("FAIL sub_neg res=%h z=%b want=fffffffe z=0",
                     result, zero);
        end
        drive(SUB, 32'h80000000, 32'h1);
        total++;
        if (result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sub_ovf res=%h v=%b want=7fffffff v=1",
                     result, overflow);
        end
    endtask

    task automatic test_slt;
        drive(SLT, 32'hFFFFFFFF, 32'h1);
        total++;
        if (result !== 32'h1) begin
            bad++;
            $display("FAIL slt_neg res=%h want=1", result);
        end
        drive(SLTU, 32'hFFFFFFFF, 32'h1);
        total++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL sltu_big res=%h z=%b want=0 z=1",
                     result, zero);
        end
        drive(SLT, 32'h80000000, 32'h7FFFFFFF);
        total++;
        if (result !== 32'h1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL slt_ovf res=%h v=%b want=1 v=0",
                     result, overflow);
        end
        drive(SLT, 32'h7FFFFFFF, 32'h80000000);
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL slt_rev res=%h want=0", result);
        end
        drive(SLTU, 32'h1, 32'hFFFFFFFF);
        total++;
        if (result !== 32'h1 || zero !== 1'b0) begin
            bad++;
            $display("FAIL sltu_small res=%h z=%b want=1 z=0",
                     result, zero);
        end
    endtask

    task automatic test_xor_nor;
        drive(XOR, 32'd5, 32'd6);
        total++;
        if (result !== 32'd3 || zero !== 1'b0) begin
            bad++;
            $display("FAIL xor_5_6 res=%h z=%b want=3 z=0",
                     result, zero);
        end
        drive(NOR, 32'h0, 32'h0);
        total++;
        if (result !== 32'hFFFFFFFF || zero !== 1'b0 ||
            overflow !== 1'b0) begin
            bad++;
            $display("FAIL nor_zero res=%h z=%b v=%b want=ffffffff",
                     result, zero, overflow);
        end
    endtask

    task automatic test_flags;
        logic [2:0]  op[5];
        logic [31:0] va[5];
        logic [31:0] vb[5];
        logic [3:0]  exp[5];
        op = '{ADD, ADD, SUB, SUB, AND};
        va = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd3,
               32'hFFFFFFFF};
        vb = '{32'h1, 32'h1, 32'd5, 32'd5, 32'hFFFFFFFF};
        exp = '{4'b0110, 4'b1001, 4'b0110, 4'b1000, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(op[i], va[i], vb[i]);
            @(posedge clk);
            #1;
            total++;
            if (flags_q !== exp[i]) begin
                bad++;
                $display("FAIL flags%0d flags_q=%b want=%b",
                         i, flags_q, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(ADD, 32'hFFFFFFFF, 32'h1);
        @(posedge clk);
        #2;
        total++;
        if (flags_q !== 4'b0110) begin
            bad++;
            $display("FAIL pre_drop flags_q=%b want=0110", flags_q);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (flags_q !== 4'b0000 || result !== 32'h0 ||
            zero !== 1'b1) begin
            bad++;
            $display("FAIL async_drop flags_q=%b res=%h z=%b",
                     flags_q, result, zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (flags_q !== 4'b0110) begin
            bad++;
            $display("FAIL post_release flags_q=%b want=0110",
                     flags_q);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        a = '0;
        b = '0;
        alucontrol = AND;
        test_reset();
        test_and();
        test_or();
        test_addsub();
        test_slt();
        test_xor_nor();
        test_flags();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
